// File: rtl/plb_bram_pkg.sv
// rtl/plb_bram_pkg.sv - shared types and constants for the PLB BRAM burst master
package plb_bram_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  localparam int LEN_W = 4;

  // Number of byte-offset address bits dropped when aligning to a BRAM word
  function automatic int align_bits(input int num_we);
    return $clog2(num_we);
  endfunction

endpackage

// File: rtl/plb_bram_rd_buf.sv
// rtl/plb_bram_rd_buf.sv - 2-entry read-return FIFO of {data, last}
module plb_bram_rd_buf #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic          head_valid,
  output logic [1:0]    count
);

  logic [DW-1:0] data_q [2];
  logic [1:0]    last_q;
  logic          wr_ptr;
  logic          rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data  = data_q[rd_ptr];
  assign head_last  = last_q[rd_ptr];
  assign head_valid = (count != 2'd0);

endmodule

// File: rtl/plb_bram_burst_master.sv
// rtl/plb_bram_burst_master.sv - request/burst sequencer driving BRAM port A
module plb_bram_burst_master
  import plb_bram_pkg::*;
#(
  parameter int C_DWIDTH  = 64,
  parameter int C_AWIDTH  = 32,
  parameter int C_NUM_WE  = 8,
  parameter int C_MEMSIZE = 'h4000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [C_AWIDTH-1:0] req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [C_NUM_WE-1:0] req_be,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [C_DWIDTH-1:0] wdata,
  output logic                rdata_valid,
  input  logic                rdata_ready,
  output logic [C_DWIDTH-1:0] rdata,
  output logic                rdata_last,
  output logic                wr_done,
  output logic                BRAM_Rst,
  output logic                BRAM_EN,
  output logic [C_NUM_WE-1:0] BRAM_WEN,
  output logic [C_AWIDTH-1:0] BRAM_Addr,
  output logic [C_DWIDTH-1:0] BRAM_Dout,
  input  logic [C_DWIDTH-1:0] BRAM_Din
);

  localparam int AL = align_bits(C_NUM_WE);
  localparam logic [C_AWIDTH-1:0] ALIGN_MASK = ~C_AWIDTH'((1 << AL) - 1);
  localparam logic [C_AWIDTH-1:0] WRAP_MASK  = C_AWIDTH'(C_MEMSIZE - 1);

  function automatic logic [C_AWIDTH-1:0] next_addr(input logic [C_AWIDTH-1:0] a);
    return (a & ~WRAP_MASK) | ((a + C_AWIDTH'(C_NUM_WE)) & WRAP_MASK);
  endfunction

  state_t              state;
  logic [C_AWIDTH-1:0] cur_addr;
  logic [LEN_W-1:0]    beats_left;
  logic [C_NUM_WE-1:0] be_q;
  logic                en_rd, en_last;   // read beat on BRAM_EN this cycle
  logic                p1_rd, p1_last;   // read data presented on BRAM_Din this cycle
  logic                wr_last;
  logic [1:0]          buf_count;
  logic [2:0]          load;
  logic                pop, accept, wbeat, can_issue;
  logic [C_AWIDTH-1:0] aligned;

  assign BRAM_Rst = ~RST_N;
  assign pop      = rdata_valid & rdata_ready;
  assign accept   = req_valid & req_ready;
  assign wbeat    = wdata_valid & wdata_ready;
  assign aligned  = req_addr & ALIGN_MASK;

  // Buffered plus outstanding reads, after this cycle's pop, must leave a slot free
  assign load      = {1'b0, buf_count} - {2'b0, pop} + {2'b0, en_rd} + {2'b0, p1_rd};
  assign can_issue = (load < 3'd2);

  plb_bram_rd_buf #(.DW(C_DWIDTH)) u_rd_buf (
    .clk        (CLK),
    .rst_n      (RST_N),
    .push       (p1_rd),
    .push_data  (BRAM_Din),
    .push_last  (p1_last),
    .pop        (pop),
    .head_data  (rdata),
    .head_last  (rdata_last),
    .head_valid (rdata_valid),
    .count      (buf_count)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      wr_done     <= 1'b0;
      wr_last     <= 1'b0;
      BRAM_EN     <= 1'b0;
      BRAM_WEN    <= '0;
      BRAM_Addr   <= '0;
      BRAM_Dout   <= '0;
      cur_addr    <= '0;
      beats_left  <= '0;
      be_q        <= '0;
      en_rd       <= 1'b0;
      en_last     <= 1'b0;
      p1_rd       <= 1'b0;
      p1_last     <= 1'b0;
    end else begin
      p1_rd    <= en_rd;
      p1_last  <= en_last;
      wr_done  <= wr_last;
      wr_last  <= 1'b0;
      BRAM_EN  <= 1'b0;
      BRAM_WEN <= '0;
      en_rd    <= 1'b0;
      en_last  <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready  <= 1'b0;
            be_q       <= req_be;
            beats_left <= req_len;
            if (req_write) begin
              cur_addr    <= aligned;
              wdata_ready <= 1'b1;
              state       <= WR;
            end else begin
              // First read beat goes out on the accept edge to keep latency at 2
              BRAM_EN   <= 1'b1;
              BRAM_Addr <= aligned;
              en_rd     <= 1'b1;
              en_last   <= (req_len == '0);
              cur_addr  <= next_addr(aligned);
              state     <= (req_len == '0) ? DRAIN : RD;
            end
          end
        end
        WR: begin
          if (wbeat) begin
            BRAM_EN   <= 1'b1;
            BRAM_WEN  <= be_q;
            BRAM_Addr <= cur_addr;
            BRAM_Dout <= wdata;
            cur_addr  <= next_addr(cur_addr);
            if (beats_left == '0) begin
              wr_last     <= 1'b1;
              wdata_ready <= 1'b0;
              req_ready   <= 1'b1;
              state       <= IDLE;
            end else begin
              beats_left <= beats_left - LEN_W'(1);
            end
          end
        end
        RD: begin
          if (can_issue) begin
            BRAM_EN    <= 1'b1;
            BRAM_Addr  <= cur_addr;
            en_rd      <= 1'b1;
            en_last    <= (beats_left == LEN_W'(1));
            cur_addr   <= next_addr(cur_addr);
            beats_left <= beats_left - LEN_W'(1);
            if (beats_left == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!en_rd && !p1_rd && buf_count == 2'd0) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plb_bram_burst_master.sv
// tb/tb_plb_bram_burst_master.sv - directed self-checking bench for plb_bram_burst_master
module tb_plb_bram_burst_master;

  logic        CLK;
  logic        RST_N;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [7:0]  req_be;
  logic        wdata_valid, wdata_ready;
  logic [63:0] wdata;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [63:0] rdata;
  logic        wr_done, BRAM_Rst, BRAM_EN;
  logic [7:0]  BRAM_WEN;
  logic [31:0] BRAM_Addr;
  logic [63:0] BRAM_Dout;
  bit   [63:0] din_q;

  int checks = 0;
  int errors = 0;

  bit [63:0] mem [0:2047];

  plb_bram_burst_master dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_be(req_be),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .wr_done(wr_done), .BRAM_Rst(BRAM_Rst),
    .BRAM_EN(BRAM_EN), .BRAM_WEN(BRAM_WEN), .BRAM_Addr(BRAM_Addr),
    .BRAM_Dout(BRAM_Dout), .BRAM_Din(din_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Read-first synchronous BRAM with byte write enables, 16 KiB
  always @(posedge CLK) begin
    if (BRAM_EN) begin
      for (int b = 0; b < 8; b++)
        if (BRAM_WEN[b]) mem[BRAM_Addr[13:3]][b*8 +: 8] <= BRAM_Dout[b*8 +: 8];
      din_q <= mem[BRAM_Addr[13:3]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] a);
    return (a & ~32'h3FFF) | ((a + 32'd8) & 32'h3FFF);
  endfunction

  task automatic send_req(input logic w, input logic [31:0] a, input logic [3:0] l,
                          input logic [7:0] be);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_be = be;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin
      step();
      n++;
    end
    check(tag, req_ready, 1'b1);
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                             input logic [7:0] be, input logic [63:0] base);
    logic [31:0] a;
    send_req(1'b1, addr, len, be);
    a = addr & ~32'h7;
    wdata_valid = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = base + 64'(i);
      step();
      check("wr_en", BRAM_EN, 1'b1);
      check("wr_wen", BRAM_WEN, be);
      check("wr_addr", BRAM_Addr, a);
      check("wr_dout", BRAM_Dout, base + 64'(i));
      check("wr_done_early", wr_done, 1'b0);
      a = nxt(a);
    end
    wdata_valid = 1'b0;
    step();
    check("wr_done", wr_done, 1'b1);
    check("wr_en_off", BRAM_EN, 1'b0);
    step();
    check("wr_done_pulse", wr_done, 1'b0);
  endtask

  // mode 0: rdata_ready held high; mode 1: rdata_ready pattern 1,0,0,1,0,0...
  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len,
                            input int mode, input logic [63:0] first);
    logic [31:0] a;
    int issued, popped, first_valid;
    bit ovf;
    a = addr & ~32'h7;
    issued = 0; popped = 0; first_valid = -1; ovf = 1'b0;
    send_req(1'b0, addr, len, 8'h00);
    for (int t = 0; t < 60 && popped <= int'(len); t++) begin
      if (BRAM_EN && BRAM_WEN == 8'h00) begin
        check("rd_addr", BRAM_Addr, a);
        a = nxt(a);
        issued++;
      end
      if (issued - popped > 2) ovf = 1'b1;
      if (rdata_valid && first_valid < 0) first_valid = t;
      rdata_ready = (mode == 0) ? 1'b1 : (t % 3 == 0);
      if (rdata_valid && rdata_ready) begin
        check("rd_data", rdata, first + 64'(popped));
        check("rd_last", rdata_last, popped == int'(len));
        popped++;
      end
      step();
    end
    rdata_ready = 1'b0;
    check("rd_beats", 64'(popped), 64'(len) + 64'd1);
    check("rd_issued", 64'(issued), 64'(len) + 64'd1);
    check("rd_latency", 64'(first_valid), 64'd2);
    check("rd_outstanding_ovf", ovf, 1'b0);
    wait_idle("rd_back_to_idle");
  endtask

  initial begin
    bit seen;
    RST_N = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_be = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    step();
    step();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_bram_rst", BRAM_Rst, 1'b1);
    check("rst_en", BRAM_EN, 1'b0);
    check("rst_wdata_ready", wdata_ready, 1'b0);
    check("rst_rdata_valid", rdata_valid, 1'b0);
    check("rst_wr_done", wr_done, 1'b0);
    RST_N = 1'b1;
    step();
    check("rel_bram_rst", BRAM_Rst, 1'b0);

    // Single write
    write_burst(32'h0010, 4'd0, 8'hFF, 64'h0123_4567_89AB_CDEF);
    check("wr_single_mem", mem[2], 64'h0123_4567_89AB_CDEF);

    // Preload words 0..3 with 1..4, then read them back
    write_burst(32'h0000, 4'd3, 8'hFF, 64'd1);
    check("preload_mem3", mem[3], 64'd4);
    read_burst(32'h0000, 4'd3, 0, 64'd1);
    read_burst(32'h0000, 4'd3, 1, 64'd1);

    // Wrapping write with partial byte enables
    write_burst(32'h3FF8, 4'd1, 8'h0F, 64'hAAAA_BBBB_CCCC_0001);
    check("wrap_mem_top", mem[11'h7FF], 64'h0000_0000_CCCC_0001);
    check("wrap_mem_zero", mem[0], 64'h0000_0000_CCCC_0002);

    // Reset during beat 3 of an 8-beat write
    send_req(1'b1, 32'h0100, 4'd7, 8'hFF);
    wdata_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 64'h100 + 64'(i);
      step();
    end
    check("rst_mid_en_before", BRAM_EN, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    check("rst_mid_en", BRAM_EN, 1'b0);
    check("rst_mid_wen", BRAM_WEN, 8'h00);
    check("rst_mid_bram_rst", BRAM_Rst, 1'b1);
    check("rst_mid_wdata_ready", wdata_ready, 1'b0);
    wdata_valid = 1'b0;
    seen = 1'b0;
    repeat (3) begin step(); seen |= wr_done; end
    RST_N = 1'b1;
    repeat (3) begin step(); seen |= wr_done; end
    check("rst_mid_no_done", seen, 1'b0);
    check("rst_mid_mem0", mem[11'h20], 64'h100);
    check("rst_mid_mem1", mem[11'h21], 64'h101);
    check("rst_mid_mem2_unwritten", mem[11'h22], 64'h0);

    // Single-beat read held off by rdata_ready
    send_req(1'b0, 32'h0108, 4'd0, 8'h00);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", rdata_valid, 1'b1);
      check("hold_data", rdata, 64'h101);
      check("hold_last", rdata_last, 1'b1);
      check("hold_req_ready", req_ready, 1'b0);
      step();
    end
    rdata_ready = 1'b1;
    step();
    rdata_ready = 1'b0;
    check("hold_popped", rdata_valid, 1'b0);
    wait_idle("hold_back_to_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
